mem_writeback: RTL and testbench

//  6502 memory write/stack-push engine; the write-side counterpart of the instruction fetcher.

---
 rtl/mem_writeback.sv | 154 +++++++++++++++
 tb/tb_mem_writeback.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// 6502 write-side engine: sequences a single-byte store or a 1-3 byte push to the stack page,
// one registered bus write per cycle, then pulses wb_done while keeping sp_next current.
module mem_writeback #(
  parameter int          REG_WIDTH  = 8,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_start,
  input  logic [1:0]            wb_mode,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  status_in,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [REG_WIDTH-1:0]  data_out,
  output logic                  write_en,
  output logic [REG_WIDTH-1:0]  sp_next,
  output logic                  busy,
  output logic                  wb_done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [1:0]           MODE_STORE = 2'b00;
  localparam logic [1:0]           MODE_PUSH1 = 2'b01;
  localparam logic [1:0]           MODE_PUSH2 = 2'b10;
  localparam logic [REG_WIDTH-1:0] SP_ONE     = 1;
  localparam logic [REG_WIDTH-1:0] SP_RESET   = 8'hFD;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [REG_WIDTH-1:0]  data_reg, data_next;
  logic                  we_reg, we_next;
  logic [REG_WIDTH-1:0]  sp_out_reg, sp_out_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  // sp_work holds the SP value after the byte currently on the bus has been written
  logic [REG_WIDTH-1:0]  sp_work_reg, sp_work_next;
  logic [1:0]            remain_reg, remain_next;
  logic [REG_WIDTH-1:0]  pend_reg [2];
  logic [REG_WIDTH-1:0]  pend_next [2];

  logic accept;
  assign accept = wb_start && (state_reg != WRITE);

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    we_next      = 1'b0;
    sp_out_next  = sp_out_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    sp_work_next = sp_work_reg;
    remain_next  = remain_reg;
    pend_next[0] = pend_reg[0];
    pend_next[1] = pend_reg[1];

    case (state_reg)
      IDLE, DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
        if (accept) begin
          // First byte goes on the bus at the accepting edge; the rest queue in pend.
          state_next   = WRITE;
          busy_next    = 1'b1;
          we_next      = 1'b1;
          sp_out_next  = sp_in;
          pend_next[0] = pc_in[REG_WIDTH-1:0];
          pend_next[1] = status_in;
          if (wb_mode == MODE_STORE) begin
            addr_next    = addr_in;
            data_next    = data_in;
            sp_work_next = sp_in;
            remain_next  = 2'd0;
          end else begin
            addr_next    = ADDR_WIDTH'({STACK_PAGE, sp_in});
            sp_work_next = sp_in - SP_ONE;
            if (wb_mode == MODE_PUSH1) begin
              data_next   = data_in;
              remain_next = 2'd0;
            end else begin
              data_next   = pc_in[ADDR_WIDTH-1 -: REG_WIDTH];
              remain_next = (wb_mode == MODE_PUSH2) ? 2'd1 : 2'd2;
            end
          end
        end
      end
      WRITE: begin
        sp_out_next = sp_work_reg;
        if (remain_reg != 2'd0) begin
          we_next      = 1'b1;
          addr_next    = ADDR_WIDTH'({STACK_PAGE, sp_work_reg});
          data_next    = pend_reg[0];
          pend_next[0] = pend_reg[1];
          sp_work_next = sp_work_reg - SP_ONE;
          remain_next  = remain_reg - 2'd1;
        end else begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      we_reg      <= 1'b0;
      sp_out_reg  <= SP_RESET;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      sp_work_reg <= SP_RESET;
      remain_reg  <= 2'd0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      we_reg      <= we_next;
      sp_out_reg  <= sp_out_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sp_work_reg <= sp_work_next;
      remain_reg  <= remain_next;
    end
  end

  // Pending byte queue is pure datapath and needs no reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      always_ff @(posedge clk) begin
        pend_reg[gi] <= pend_next[gi];
      end
    end
  endgenerate

  assign addr     = addr_reg;
  assign data_out = data_reg;
  assign write_en = we_reg;
  assign sp_next  = sp_out_reg;
  assign busy     = busy_reg;
  assign wb_done  = done_reg;

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: stimulus queues expected writes/completions with their
// cycle stamps; a negedge monitor pops and compares whenever write_en or wb_done is seen.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_start;
  logic [1:0]  wb_mode;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [15:0] pc_in;
  logic [7:0]  status_in;
  logic [7:0]  sp_in;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        write_en;
  logic [7:0]  sp_next;
  logic        busy;
  logic        wb_done;

  mem_writeback dut (
    .clk(clk), .reset_n(reset_n), .wb_start(wb_start), .wb_mode(wb_mode),
    .addr_in(addr_in), .data_in(data_in), .pc_in(pc_in), .status_in(status_in),
    .sp_in(sp_in), .addr(addr), .data_out(data_out), .write_en(write_en),
    .sp_next(sp_next), .busy(busy), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [7:0] sp; } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every DUT write and completion against the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (write_en === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected write at cyc %0d addr=%h data=%h", cyc, addr, data_out);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          if (addr !== e.a || data_out !== e.d || cyc != e.cyc || busy !== 1'b1) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h cyc=%0d busy=%b, want addr=%h data=%h cyc=%0d busy=1",
                     addr, data_out, cyc, busy, e.a, e.d, e.cyc);
          end else
            $display("write ok: cyc %0d %h <= %h", cyc, addr, data_out);
        end
      end
      if (wb_done === 1'b1) begin
        checks++;
        if (dn_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected wb_done at cyc %0d sp_next=%h", cyc, sp_next);
        end else begin
          dn_t e;
          e = dn_q.pop_front();
          if (sp_next !== e.sp || cyc != e.cyc || busy !== 1'b0 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL done: got sp_next=%h cyc=%0d busy=%b we=%b, want sp_next=%h cyc=%0d busy=0 we=0",
                     sp_next, cyc, busy, write_en, e.sp, e.cyc);
          end else
            $display("done ok: cyc %0d sp_next=%h", cyc, sp_next);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else
      $display("check ok: %s = %h", name, got);
  endtask

  // Called just after a negedge; drives a request and queues its expected results.
  // nw writes follow; exp_sp is the expected sp_next at completion.
  task automatic issue(input logic [1:0] mode, input logic [15:0] a, input logic [7:0] d,
                       input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                       input int nw, input logic [15:0] wa[3], input logic [7:0] wd[3],
                       input logic [7:0] exp_sp, input bit expect_done);
    int acc;
    wb_mode = mode; addr_in = a; data_in = d; pc_in = pc; status_in = st; sp_in = sp;
    wb_start = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < nw; k++) wr_q.push_back('{acc + k, wa[k], wd[k]});
    if (expect_done) dn_q.push_back('{acc + nw, exp_sp});
    @(posedge clk);
    @(negedge clk);
    wb_start = 1'b0;
    // Inputs changing after acceptance must not matter.
    addr_in = 16'hDEAD; data_in = 8'hEE; pc_in = 16'hBEEF; status_in = 8'h11; sp_in = 8'h55;
  endtask

  task automatic wait_done();
    int n = 0;
    while (wb_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (wb_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: wb_done not seen, got 0 want 1");
    end
  endtask

  logic [15:0] wa[3];
  logic [7:0]  wd[3];

  initial begin
    reset_n = 1'b0; wb_start = 1'b0; wb_mode = 2'b00; addr_in = '0; data_in = '0;
    pc_in = '0; status_in = '0; sp_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset addr", addr, 16'h0000);
    check("reset data_out", {8'h00, data_out}, 16'h0000);
    check("reset write_en", {15'd0, write_en}, 16'h0000);
    check("reset busy", {15'd0, busy}, 16'h0000);
    check("reset wb_done", {15'd0, wb_done}, 16'h0000);
    check("reset sp_next", {8'h00, sp_next}, 16'h00FD);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // STORE
    wa = '{16'h1234, 16'h0, 16'h0}; wd = '{8'hAB, 8'h0, 8'h0};
    issue(2'b00, 16'h1234, 8'hAB, 16'h0, 8'h0, 8'hF0, 1, wa, wd, 8'hF0, 1'b1);
    wait_done(); @(negedge clk);

    // PUSH3 from FD
    wa = '{16'h01FD, 16'h01FC, 16'h01FB}; wd = '{8'hC0, 8'h12, 8'h34};
    issue(2'b11, 16'h0, 8'h0, 16'hC012, 8'h34, 8'hFD, 3, wa, wd, 8'hFA, 1'b1);
    wait_done(); @(negedge clk);

    // PUSH2 wrapping 00 -> FF inside page 1
    wa = '{16'h0100, 16'h01FF, 16'h0}; wd = '{8'hAB, 8'hCD, 8'h0};
    issue(2'b10, 16'h0, 8'h0, 16'hABCD, 8'h0, 8'h00, 2, wa, wd, 8'hFE, 1'b1);
    wait_done(); @(negedge clk);

    // PUSH3 with an ignored STORE mid-flight, then a back-to-back STORE in DONE
    wa = '{16'h0180, 16'h017F, 16'h017E}; wd = '{8'h56, 8'h78, 8'hA5};
    issue(2'b11, 16'h0, 8'h0, 16'h5678, 8'hA5, 8'h80, 3, wa, wd, 8'h7D, 1'b1);
    wb_mode = 2'b00; addr_in = 16'h4444; data_in = 8'h99; sp_in = 8'h10; wb_start = 1'b1;
    @(negedge clk);
    wb_start = 1'b0;
    wait_done();
    wa = '{16'h0200, 16'h0, 16'h0}; wd = '{8'h5A, 8'h0, 8'h0};
    issue(2'b00, 16'h0200, 8'h5A, 16'h0, 8'h0, 8'h33, 1, wa, wd, 8'h33, 1'b1);
    wait_done(); @(negedge clk);

    // PUSH1 from 01
    wa = '{16'h0101, 16'h0, 16'h0}; wd = '{8'h77, 8'h0, 8'h0};
    issue(2'b01, 16'h0, 8'h77, 16'h0, 8'h0, 8'h01, 1, wa, wd, 8'h00, 1'b1);
    wait_done(); @(negedge clk);

    // PUSH3 aborted by reset right after its first write
    wa = '{16'h01FD, 16'h0, 16'h0}; wd = '{8'hC0, 8'h0, 8'h0};
    issue(2'b11, 16'h0, 8'h0, 16'hC012, 8'h34, 8'hFD, 1, wa, wd, 8'h00, 1'b0);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("abort write_en", {15'd0, write_en}, 16'h0000);
    check("abort busy", {15'd0, busy}, 16'h0000);
    check("abort wb_done", {15'd0, wb_done}, 16'h0000);
    check("abort sp_next", {8'h00, sp_next}, 16'h00FD);
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    check("leftover writes", 16'(wr_q.size()), 16'h0000);
    check("leftover dones", 16'(dn_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
